// File: rtl/bicubic_upsample_pipe_if.sv
// Window-in / block-out handshake bundle for the bicubic upsampler.
// master = window source + block sink side, slave = upsampler side.
interface bicubic_upsample_pipe_if #(
    parameter int CHANNEL_WIDTH = 8
);
    logic                       bf_req_valid;
    logic                       bcci_req_ready;
    logic [16*CHANNEL_WIDTH-1:0] bf_win;
    logic                       bcci_rsp_valid;
    logic                       bf_rsp_ready;
    logic [16*CHANNEL_WIDTH-1:0] bcci_rsp_data;

    modport master (
        output bf_req_valid,
        output bf_win,
        output bf_rsp_ready,
        input  bcci_req_ready,
        input  bcci_rsp_valid,
        input  bcci_rsp_data
    );

    modport slave (
        input  bf_req_valid,
        input  bf_win,
        input  bf_rsp_ready,
        output bcci_req_ready,
        output bcci_rsp_valid,
        output bcci_rsp_data
    );
endinterface

// File: rtl/bicubic_upsample_pipe.sv
// Two-stage separable 4x bicubic upsampler (vertical then horizontal pass).
// Optional output-block counter: define BICUBIC_BLK_CNT_EN.
module bicubic_upsample_pipe #(
    parameter int CHANNEL_WIDTH = 8,
    parameter int FRAC_BITS     = 7,
    parameter int ACC_WIDTH     = CHANNEL_WIDTH + 2*FRAC_BITS + 4
) (
    input  logic clk,
    input  logic rst_n,
    bicubic_upsample_pipe_if.slave bus
`ifdef BICUBIC_BLK_CNT_EN
    ,
    output logic [31:0] bcci_blk_cnt,
    input  logic        clr_blk_cnt
`endif
);
    localparam int CW    = CHANNEL_WIDTH;
    localparam int TW    = CHANNEL_WIDTH + FRAC_BITS + 2;
    localparam int WW    = FRAC_BITS + 2;
    localparam int SHIFT = 2 * FRAC_BITS;
    localparam logic signed [ACC_WIDTH-1:0] RND =
        ACC_WIDTH'(1) <<< (SHIFT - 1);

    if (FRAC_BITS != 7) begin : g_bad_frac
        $error("bicubic_upsample_pipe: taps are fixed for FRAC_BITS=7");
    end

    // Signed filter taps, each phase sums to 128.
    function automatic logic signed [WW-1:0] tap(
        input logic [1:0] ph,
        input logic [1:0] k
    );
        logic signed [WW-1:0] w;
        w = '0;
        case ({ph, k})
            4'h1:    w = WW'(128);
            4'h4:    w = WW'(-9);
            4'h5:    w = WW'(111);
            4'h6:    w = WW'(29);
            4'h7:    w = WW'(-3);
            4'h8:    w = WW'(-8);
            4'h9:    w = WW'(72);
            4'hA:    w = WW'(72);
            4'hB:    w = WW'(-8);
            4'hC:    w = WW'(-3);
            4'hD:    w = WW'(29);
            4'hE:    w = WW'(111);
            4'hF:    w = WW'(-9);
            default: w = '0;
        endcase
        return w;
    endfunction

    // Unsigned source sample (r,c) widened to a signed stage-1 operand.
    function automatic logic signed [TW-1:0] pix(
        input logic [16*CW-1:0] win,
        input int               r,
        input int               c
    );
        return TW'($signed({1'b0, win[(r*4+c)*CW +: CW]}));
    endfunction

    logic                 s1_valid_q;
    logic                 s2_valid_q;
    logic                 adv;
    logic signed [TW-1:0] t_d [4][4];
    logic signed [TW-1:0] t_q [4][4];
    logic [16*CW-1:0]     out_d;
    logic [16*CW-1:0]     out_q;

    assign adv                 = ~s2_valid_q | bus.bf_rsp_ready;
    assign bus.bcci_req_ready  = adv;
    assign bus.bcci_rsp_valid  = s2_valid_q;
    assign bus.bcci_rsp_data   = out_q;

    // Vertical pass: full-precision column filter per output phase row.
    always_comb begin
        logic signed [TW-1:0] acc;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < 4; c++) begin
                acc = '0;
                for (int r = 0; r < 4; r++) begin
                    acc = acc + TW'(tap(2'(i), 2'(r))) * pix(bus.bf_win, r, c);
                end
                t_d[i][c] = acc;
            end
        end
    end

    // Horizontal pass, round half-up, then clamp to the pixel range.
    always_comb begin
        logic signed [ACC_WIDTH-1:0] a;
        logic signed [ACC_WIDTH-1:0] rs;
        logic [CW-1:0]               px;
        a     = '0;
        rs    = '0;
        px    = '0;
        out_d = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a = '0;
                for (int c = 0; c < 4; c++) begin
                    a = a + ACC_WIDTH'(t_q[i][c]) *
                            ACC_WIDTH'(tap(2'(j), 2'(c)));
                end
                rs = (a + RND) >>> SHIFT;
                if (rs[ACC_WIDTH-1]) begin
                    px = '0;
                end else if (|rs[ACC_WIDTH-2:CW]) begin
                    px = '1;
                end else begin
                    px = rs[CW-1:0];
                end
                out_d[(i*4+j)*CW +: CW] = px;
            end
        end
    end

    // Both stages shift together on adv and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            t_q        <= '{default: '0};
            out_q      <= '0;
        end else if (adv) begin
            s1_valid_q <= bus.bf_req_valid;
            s2_valid_q <= s1_valid_q;
            t_q        <= t_d;
            out_q      <= out_d;
        end
    end

`ifdef BICUBIC_BLK_CNT_EN
    logic [31:0] blk_cnt_q;

    assign bcci_blk_cnt = blk_cnt_q;

    // Count output handshakes; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_cnt_q <= '0;
        end else if (clr_blk_cnt) begin
            blk_cnt_q <= '0;
        end else if (s2_valid_q & bus.bf_rsp_ready) begin
            blk_cnt_q <= blk_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bicubic_upsample_pipe.sv
// Scoreboard bench for bicubic_upsample_pipe.
// Define BICUBIC_BLK_CNT_EN to also exercise the block counter.
module tb_bicubic_upsample_pipe;
    logic clk;
    logic rst_n;
`ifdef BICUBIC_BLK_CNT_EN
    logic [31:0] blk_cnt;
    logic        clr_blk_cnt;
`endif

    bicubic_upsample_pipe_if #(.CHANNEL_WIDTH(8)) bus ();

    bicubic_upsample_pipe #(
        .CHANNEL_WIDTH(8),
        .FRAC_BITS(7)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef BICUBIC_BLK_CNT_EN
        ,
        .bcci_blk_cnt(blk_cnt),
        .clr_blk_cnt(clr_blk_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int W [4][4] = '{
        '{0, 128, 0, 0},
        '{-9, 111, 29, -3},
        '{-8, 72, 72, -8},
        '{-3, 29, 111, -9}
    };

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nout  = 0;
    bit m1    = 0;
    bit m2    = 0;
    bit lat_chk = 0;
    logic [127:0] q [$];
    int           pq [$];
    logic [127:0] last_out;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Direct 2-D form of the filter with round half-up and clamp.
    function automatic logic [127:0] model(input logic [127:0] w);
        logic [127:0] res;
        int a;
        int rs;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                a = 0;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        a += W[i][r] * W[j][c] * int'(w[(r*4+c)*8 +: 8]);
                    end
                end
                rs = (a + 8192) >>> 14;
                if (rs < 0) rs = 0;
                if (rs > 255) rs = 255;
                res[(i*4+j)*8 +: 8] = 8'(rs);
            end
        end
        return res;
    endfunction

    function automatic logic [127:0] rowwin(input logic [7:0] c0,
        input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
        logic [127:0] w;
        for (int r = 0; r < 4; r++) begin
            w[(r*4+0)*8 +: 8] = c0;
            w[(r*4+1)*8 +: 8] = c1;
            w[(r*4+2)*8 +: 8] = c2;
            w[(r*4+3)*8 +: 8] = c3;
        end
        return w;
    endfunction

    function automatic logic [127:0] rndwin();
        logic [127:0] w;
        for (int k = 0; k < 4; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // One clock: entered at a negedge with inputs already driven.
    task automatic tick(output bit acc);
        bit adv_m;
        logic [127:0] e;
        int pc;
        #1;
        adv_m = !m2 || bus.bf_rsp_ready;
        chk("rsp_valid", bus.bcci_rsp_valid, m2);
        chk("req_ready", bus.bcci_req_ready, adv_m);
        if (m2) begin
            if (q.size() == 0) begin
                chk("sb_underflow", q.size(), 1);
            end else if (bus.bf_rsp_ready) begin
                e = q.pop_front();
                pc = pq.pop_front();
                last_out = bus.bcci_rsp_data;
                chk("data", bus.bcci_rsp_data, e);
                if (lat_chk) chk("latency", cyc - pc, 2);
                nout++;
            end else begin
                chk("hold", bus.bcci_rsp_data, q[0]);
            end
        end
        acc = bus.bf_req_valid && adv_m;
        if (acc) begin
            q.push_back(model(bus.bf_win));
            pq.push_back(cyc);
        end
        if (adv_m) begin
            m2 = m1;
            m1 = bus.bf_req_valid;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [127:0] w);
        bit a;
        bus.bf_rsp_ready = 1'b1;
        bus.bf_req_valid = 1'b1;
        bus.bf_win       = w;
        tick(a);
        bus.bf_req_valid = 1'b0;
        repeat (3) tick(a);
    endtask

    task automatic chk_row(input string tag, input logic [127:0] o,
                           input int j, input int v);
        for (int i = 0; i < 4; i++) begin
            chk(tag, o[(i*4+j)*8 +: 8], 128'(v));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bit a;
        int n0;
        int idx;
        logic [127:0] wins [5];

        rst_n            = 1'b0;
        bus.bf_req_valid = 1'b0;
        bus.bf_win       = '0;
        bus.bf_rsp_ready = 1'b0;
`ifdef BICUBIC_BLK_CNT_EN
        clr_blk_cnt      = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", bus.bcci_rsp_valid, 0);
        chk("rst_data", bus.bcci_rsp_data, 0);
        chk("rst_ready", bus.bcci_req_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;

        // flat field, latency 2
        n0 = nout;
        lat_chk = 1'b1;
        send({16{8'd100}});
        lat_chk = 1'b0;
        chk("flat_cnt", nout - n0, 1);
        chk("flat_val", last_out, {16{8'd100}});

        // edge ramp with exact half rounding
        send(rowwin(0, 0, 255, 255));
        chk_row("ramp_j0", last_out, 0, 0);
        chk_row("ramp_j1", last_out, 1, 52);
        chk_row("ramp_j2", last_out, 2, 128);
        chk_row("ramp_j3", last_out, 3, 203);

        // overshoot clamps to full scale
        send(rowwin(0, 255, 255, 0));
        chk_row("ovf_j1", last_out, 1, 255);
        chk_row("ovf_j2", last_out, 2, 255);

        // undershoot clamps to zero
        send(rowwin(255, 0, 0, 0));
        chk_row("neg_j1", last_out, 1, 0);

        // five blocks back-to-back with a four-cycle output stall
        for (int k = 0; k < 5; k++) wins[k] = rndwin();
        n0  = nout;
        idx = 0;
        for (int n = 0; n < 40; n++) begin
            if (idx == 5 && q.size() == 0) break;
            bus.bf_rsp_ready = !(n >= 3 && n <= 6);
            bus.bf_req_valid = (idx < 5);
            bus.bf_win       = (idx < 5) ? wins[idx] : '0;
            tick(a);
            if (a) idx++;
        end
        bus.bf_req_valid = 1'b0;
        chk("stall_blocks", nout - n0, 5);

        // random valid/ready traffic
        for (int n = 0; n < 60; n++) begin
            bus.bf_rsp_ready = 1'($urandom_range(0, 1));
            bus.bf_req_valid = 1'($urandom_range(0, 1));
            bus.bf_win       = rndwin();
            tick(a);
        end
        bus.bf_req_valid = 1'b0;
        bus.bf_rsp_ready = 1'b1;
        repeat (4) tick(a);
        chk("rand_drain", q.size(), 0);

        // fill both stages, then reset in mid-cycle
        bus.bf_rsp_ready = 1'b0;
        bus.bf_req_valid = 1'b1;
        bus.bf_win       = rndwin();
        tick(a);
        bus.bf_win       = rndwin();
        tick(a);
        bus.bf_req_valid = 1'b0;
        chk("pre_rst_valid", bus.bcci_rsp_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", bus.bcci_rsp_valid, 0);
        chk("mid_rst_data", bus.bcci_rsp_data, 0);
        chk("mid_rst_ready", bus.bcci_req_ready, 1);
        m1 = 0;
        m2 = 0;
        q.delete();
        pq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n0 = nout;
        lat_chk = 1'b1;
        send(rowwin(10, 20, 30, 40));
        lat_chk = 1'b0;
        chk("post_rst_cnt", nout - n0, 1);

`ifdef BICUBIC_BLK_CNT_EN
        clr_blk_cnt = 1'b1;
        tick(a);
        clr_blk_cnt = 1'b0;
        chk("cnt_clr", blk_cnt, 0);
        bus.bf_rsp_ready = 1'b1;
        bus.bf_req_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus.bf_win = rndwin();
            tick(a);
        end
        bus.bf_req_valid = 1'b0;
        repeat (3) tick(a);
        chk("cnt_7", blk_cnt, 7);
        bus.bf_req_valid = 1'b1;
        bus.bf_win = rndwin();
        tick(a);
        bus.bf_req_valid = 1'b0;
        tick(a);
        clr_blk_cnt = 1'b1;
        tick(a);
        clr_blk_cnt = 1'b0;
        chk("cnt_clr_hs", blk_cnt, 0);
        force dut.blk_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.blk_cnt_q;
        @(negedge clk);
        send(rndwin());
        chk("cnt_wrap", blk_cnt, 0);
`endif

        chk("sb_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
